// File: rtl/alu_session_sequencer.sv
// Credential-gated nibble sequencer driving a combinational 4-bit ALU and returning its result via valid/ready.
// Optional STATUS_STICKY_EN adds sticky_status, an OR-accumulation of captured status bits.
module alu_session_sequencer #(
  parameter int MAX_FAILS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] in_data,
  output logic       in_ready,
  input  logic [3:0] cred,
  input  logic       logout,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [3:0] alu_op,
  input  logic [4:0] alu_r,
  input  logic [4:0] alu_status,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [4:0] res_data,
  output logic [4:0] res_status,
  output logic       unlocked,
`ifdef STATUS_STICKY_EN
  output logic [4:0] sticky_status,
`endif
  output logic [3:0] fail_cnt
);

  typedef enum logic [2:0] {
    S_LOCKED, S_GET_A, S_GET_B, S_GET_OP, S_EXEC, S_DONE, S_BLOCKED
  } state_t;

  localparam logic [3:0] LP_MAX_FAILS = 4'(MAX_FAILS);

  state_t     r_state;
  state_t     w_next;
  logic       r_settle;
  logic [3:0] r_alu_a;
  logic [3:0] r_alu_b;
  logic [3:0] r_alu_op;
  logic       r_res_valid;
  logic [4:0] r_res_data;
  logic [4:0] r_res_status;
  logic [3:0] r_fail_cnt;
  logic [4:0] r_sticky;
  logic       w_accept;
  logic       w_cred_ok;
  logic [3:0] w_fail_inc;
  logic       w_logout;

  assign w_logout   = logout && (r_state != S_BLOCKED);
  assign in_ready   = !logout && (r_state == S_LOCKED || r_state == S_GET_A ||
                                  r_state == S_GET_B  || r_state == S_GET_OP);
  assign w_accept   = in_valid && in_ready;
  assign w_cred_ok  = (in_data == cred);
  assign w_fail_inc = r_fail_cnt + 4'd1;

  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_op     = r_alu_op;
  assign res_valid  = r_res_valid;
  assign res_data   = r_res_data;
  assign res_status = r_res_status;
  assign fail_cnt   = r_fail_cnt;
  assign unlocked   = (r_state != S_LOCKED) && (r_state != S_BLOCKED);
`ifdef STATUS_STICKY_EN
  assign sticky_status = r_sticky;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_LOCKED: begin
        if (w_accept) begin
          if (w_cred_ok)                      w_next = S_GET_A;
          else if (w_fail_inc == LP_MAX_FAILS) w_next = S_BLOCKED;
        end
      end
      S_GET_A:  if (w_accept) w_next = S_GET_B;
      S_GET_B:  if (w_accept) w_next = S_GET_OP;
      S_GET_OP: if (w_accept) w_next = S_EXEC;
      S_EXEC:   if (!r_settle) w_next = S_DONE;
      S_DONE:   if (res_ready) w_next = S_GET_A;
      default:  w_next = S_BLOCKED;
    endcase
    if (w_logout) w_next = S_LOCKED;
  end

  // EXEC spends a first cycle letting the freshly loaded opcode settle through the ALU, then samples it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_LOCKED;
      r_settle     <= 1'b0;
      r_alu_a      <= 4'd0;
      r_alu_b      <= 4'd0;
      r_alu_op     <= 4'd0;
      r_res_valid  <= 1'b0;
      r_res_data   <= 5'd0;
      r_res_status <= 5'd0;
      r_fail_cnt   <= 4'd0;
      r_sticky     <= 5'd0;
    end else begin
      r_state <= w_next;
      if (w_logout) begin
        r_res_valid <= 1'b0;
        r_settle    <= 1'b0;
        r_sticky    <= 5'd0;
      end else begin
        case (r_state)
          S_LOCKED: begin
            if (w_accept) begin
              if (w_cred_ok) begin
                r_fail_cnt <= 4'd0;
                r_sticky   <= 5'd0;
              end else if (r_fail_cnt != 4'hF) begin
                r_fail_cnt <= w_fail_inc;
              end
            end
          end
          S_GET_A: if (w_accept) r_alu_a <= in_data;
          S_GET_B: if (w_accept) r_alu_b <= in_data;
          S_GET_OP: begin
            if (w_accept) begin
              r_alu_op <= in_data;
              r_settle <= 1'b1;
            end
          end
          S_EXEC: begin
            if (r_settle) begin
              r_settle <= 1'b0;
            end else begin
              r_res_data   <= alu_r;
              r_res_status <= alu_status;
              r_res_valid  <= 1'b1;
              r_sticky     <= r_sticky | alu_status;
            end
          end
          S_DONE: if (res_ready) r_res_valid <= 1'b0;
          default: ;
        endcase
      end
    end
  end

`ifndef STATUS_STICKY_EN
  logic w_sticky_unused;
  assign w_sticky_unused = ^r_sticky;
`endif

endmodule

// File: tb/tb_alu_session_sequencer.sv
// Randomized + directed bench for alu_session_sequencer against a transaction-level model.
module tb_alu_session_sequencer;
  localparam int MAXF = 3;

  logic clk, rst, in_valid, in_ready, logout, res_valid, res_ready, unlocked;
  logic [3:0] in_data, cred, alu_a, alu_b, alu_op, fail_cnt;
  logic [4:0] alu_r, alu_status, res_data, res_status;
`ifdef STATUS_STICKY_EN
  logic [4:0] sticky_status;
`endif

  int n_vec = 0;
  int n_miss = 0;
  int rdy_lit = -1;

  alu_session_sequencer #(.MAX_FAILS(MAXF)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .cred(cred), .logout(logout), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_r(alu_r), .alu_status(alu_status), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_status(res_status), .unlocked(unlocked),
`ifdef STATUS_STICKY_EN
    .sticky_status(sticky_status),
`endif
    .fail_cnt(fail_cnt)
  );

  // ALU stand-in: returns {r, status} with status = {zero, negative, carry, overflow, parity}
  function automatic logic [9:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
    logic [4:0] r;
    logic ov;
    ov = 1'b0;
    case (op)
      4'd0: begin r = {1'b0, a} + {1'b0, b}; ov = (a[3] == b[3]) && (r[3] != a[3]); end
      4'd1: begin r = {1'b0, a} - {1'b0, b}; ov = (a[3] != b[3]) && (r[3] != a[3]); end
      4'd2: r = {1'b0, a & b};
      4'd3: r = {1'b0, a | b};
      default: r = {1'b0, a ^ b};
    endcase
    return {r, (r[3:0] == 4'd0), r[3], r[4], ov, ^r[3:0]};
  endfunction

  assign {alu_r, alu_status} = alu_f(alu_a, alu_b, alu_op);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Transaction-level model of the session
  bit m_session, m_blocked, m_done;
  int m_beat, m_exec, m_fail;
  logic [3:0] m_a, m_b, m_op;
  logic m_rv;
  logic [4:0] m_rd, m_rs, m_sticky;

  task automatic model_reset();
    m_session = 0; m_blocked = 0; m_done = 0; m_beat = 1; m_exec = 0; m_fail = 0;
    m_a = 0; m_b = 0; m_op = 0; m_rv = 0; m_rd = 0; m_rs = 0; m_sticky = 0;
  endtask

  function automatic bit exp_ready();
    return !m_blocked && !logout && (!m_session || (m_exec == 0 && !m_done));
  endfunction

  task automatic model_step();
    logic [9:0] o;
    bit take;
    take = in_valid && exp_ready();
    if (m_blocked) begin
    end else if (logout) begin
      m_session = 0; m_exec = 0; m_done = 0; m_rv = 0; m_sticky = 0;
    end else if (!m_session) begin
      if (take) begin
        if (in_data == cred) begin
          m_session = 1; m_beat = 1; m_fail = 0; m_sticky = 0;
        end else begin
          m_fail = (m_fail < 15) ? m_fail + 1 : 15;
          if (m_fail == MAXF) m_blocked = 1;
        end
      end
    end else if (m_exec > 0) begin
      m_exec--;
      if (m_exec == 0) begin
        o = alu_f(m_a, m_b, m_op);
        m_rd = o[9:5]; m_rs = o[4:0]; m_rv = 1; m_done = 1; m_sticky = m_sticky | o[4:0];
      end
    end else if (m_done) begin
      if (res_ready) begin m_rv = 0; m_done = 0; m_beat = 1; end
    end else if (take) begin
      case (m_beat)
        1: begin m_a = in_data; m_beat = 2; end
        2: begin m_b = in_data; m_beat = 3; end
        default: begin m_op = in_data; m_beat = 1; m_exec = 2; end
      endcase
    end
  endtask

  task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp, inout bit bad);
    if (act !== exp) begin
      $display("FAIL %s: dut=%0h expected=%0h t=%0t", nm, act, exp, $time);
      bad = 1;
    end
  endtask

  task automatic compare();
    bit bad;
    bad = 0;
    n_vec++;
    cmp("in_ready", 8'(in_ready), 8'(exp_ready()), bad);
    cmp("unlocked", 8'(unlocked), 8'(m_session && !m_blocked), bad);
    cmp("fail_cnt", 8'(fail_cnt), 8'(m_fail), bad);
    cmp("res_valid", 8'(res_valid), 8'(m_rv), bad);
    cmp("res_data", 8'(res_data), 8'(m_rd), bad);
    cmp("res_status", 8'(res_status), 8'(m_rs), bad);
    cmp("alu_a", 8'(alu_a), 8'(m_a), bad);
    cmp("alu_b", 8'(alu_b), 8'(m_b), bad);
    cmp("alu_op", 8'(alu_op), 8'(m_op), bad);
`ifdef STATUS_STICKY_EN
    cmp("sticky", 8'(sticky_status), 8'(m_sticky), bad);
`endif
    if (bad) n_miss++;
  endtask

  task automatic lit(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      $display("FAIL %s: dut=%0h expected=%0h t=%0t", nm, act, exp, $time);
      n_miss++;
    end
  endtask

  task automatic tick(input bit iv, input logic [3:0] id, input bit lo, input bit rr);
    @(negedge clk);
    in_valid = iv; in_data = id; logout = lo; res_ready = rr;
    #1;
    compare();
    if (rdy_lit >= 0) begin
      lit("ready_literal", 8'(in_ready), 8'(rdy_lit));
      rdy_lit = -1;
    end
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    in_valid = 0; logout = 0; res_ready = 0;
    rst = 1;
    #1;
    lit("rst_in_ready", 8'(in_ready), 8'd1);
    lit("rst_unlocked", 8'(unlocked), 8'd0);
    lit("rst_res_valid", 8'(res_valid), 8'd0);
    lit("rst_res_data", 8'({res_data, res_status}), 8'd0);
    lit("rst_alu", 8'({alu_a, alu_op}), 8'd0);
    lit("rst_fail_cnt", 8'(fail_cnt), 8'd0);
    model_reset();
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    rst = 0; in_valid = 0; in_data = 0; logout = 0; res_ready = 0; cred = 4'hA;
    model_reset();
    #12 rst = 1;
    #1;
    lit("por_in_ready", 8'(in_ready), 8'd1);
    lit("por_res_valid", 8'(res_valid), 8'd0);
    @(negedge clk);
    rst = 0;

    // Login + 3 + 5
    tick(1, 4'hA, 0, 0);
    lit("login_unlocked", 8'(unlocked), 8'd1);
    lit("login_fail", 8'(fail_cnt), 8'd0);
    tick(1, 4'h3, 0, 0);
    tick(1, 4'h5, 0, 0);
    tick(1, 4'h0, 0, 0);
    lit("lat_N", 8'(res_valid), 8'd0);
    tick(0, 4'h0, 0, 0);
    lit("lat_N1", 8'(res_valid), 8'd0);
    tick(0, 4'h0, 0, 0);
    lit("lat_N2", 8'(res_valid), 8'd1);
    lit("add_data", 8'(res_data), 8'h08);
    lit("add_zero_carry", 8'({res_status[4], res_status[2]}), 8'd0);
    tick(0, 4'h0, 0, 1);
    lit("add_hs", 8'(res_valid), 8'd0);

    // Carry with held result
    tick(1, 4'hF, 0, 0);
    tick(1, 4'h1, 0, 0);
    tick(1, 4'h0, 0, 0);
    tick(0, 4'h0, 0, 0);
    tick(0, 4'h0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      lit("carry_valid", 8'(res_valid), 8'd1);
      lit("carry_data", 8'(res_data), 8'h10);
      lit("carry_bit", 8'(res_status[2]), 8'd1);
      tick(0, 4'h0, 0, 0);
    end
    tick(0, 4'h0, 0, 1);
    lit("carry_hs", 8'(res_valid), 8'd0);
    lit("carry_unlocked", 8'(unlocked), 8'd1);
`ifdef STATUS_STICKY_EN
    lit("sticky_bits", 8'({sticky_status[4], sticky_status[2]}), 8'd3);
    tick(0, 4'h0, 1, 0);
    lit("sticky_clear", 8'(sticky_status), 8'd0);
    tick(1, 4'hA, 0, 0);
`endif

    // Logout during EXEC; the same-edge beat must be refused
    tick(1, 4'h2, 0, 0);
    tick(1, 4'h3, 0, 0);
    tick(1, 4'h0, 0, 0);
    rdy_lit = 0;
    tick(1, 4'h7, 1, 1);
    lit("logout_locked", 8'(unlocked), 8'd0);
    for (int i = 0; i < 3; i++) begin
      tick(0, 4'h0, 0, 1);
      lit("logout_no_res", 8'(res_valid), 8'd0);
    end

    // Lockout
    do_reset();
    cred = 4'hA;
    tick(1, 4'h1, 0, 0);
    tick(1, 4'h2, 0, 0);
    lit("lock_fail2", 8'(fail_cnt), 8'd2);
    lit("lock_rdy2", 8'(in_ready), 8'd1);
    tick(1, 4'h4, 0, 0);
    lit("lock_fail3", 8'(fail_cnt), 8'd3);
    lit("lock_rdy3", 8'(in_ready), 8'd0);
    tick(1, 4'hA, 0, 0);
    tick(0, 4'h0, 1, 0);
    tick(1, 4'hA, 0, 0);
    lit("blocked_fail", 8'(fail_cnt), 8'd3);
    lit("blocked_unlocked", 8'(unlocked), 8'd0);
    do_reset();

    // Failure count cleared by good login
    tick(1, 4'h1, 0, 0);
    tick(1, 4'h2, 0, 0);
    tick(1, 4'hA, 0, 0);
    lit("recover_fail", 8'(fail_cnt), 8'd0);
    lit("recover_unlocked", 8'(unlocked), 8'd1);

    // Randomized traffic
    begin
      int blk_cycles;
      blk_cycles = 0;
      for (int i = 0; i < 4000; i++) begin
        logic [3:0] d;
        bit iv, lo, rr;
        if ($urandom_range(0, 49) == 0) cred = 4'($urandom_range(0, 15));
        d = 4'($urandom_range(0, 15));
        if (!m_session && ($urandom_range(0, 2) != 0)) d = cred;
        iv = ($urandom_range(0, 3) != 0);
        lo = ($urandom_range(0, 24) == 0);
        rr = ($urandom_range(0, 1) == 1);
        tick(iv, d, lo, rr);
        blk_cycles = m_blocked ? blk_cycles + 1 : 0;
        if (blk_cycles > 6 || $urandom_range(0, 399) == 0) begin
          do_reset();
          blk_cycles = 0;
        end
      end
    end
    tick(0, 4'h0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
